dot_product_ctrl: RTL and testbench

//  Sequences a vector dot product of arbitrary length over the N-lane reduction_tree.

---
 rtl/dot_product_ctrl_if.sv | 40 ++++
 rtl/dot_product_ctrl.sv | 128 ++++++++++++
 tb/tb_dot_product_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dot_product_ctrl_if.sv
// Host-side bundle for dot_product_ctrl: job request, operand beat stream and result handshake.
// The ovf signal exists only when DOT_CTRL_OVF_EN is defined.
interface dot_product_ctrl_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned LEN_W = 16
);
  localparam int unsigned DW = 32;

  logic              start;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              in_valid;
  logic              in_ready;
  logic [DW*N-1:0]   a_vec;
  logic [DW*N-1:0]   b_vec;
  logic              res_valid;
  logic              res_ready;
  logic [DW-1:0]     result;
`ifdef DOT_CTRL_OVF_EN
  logic              ovf;

  modport master (
    output start, len, in_valid, a_vec, b_vec, res_ready,
    input  busy, in_ready, res_valid, result, ovf
  );
  modport slave (
    input  start, len, in_valid, a_vec, b_vec, res_ready,
    output busy, in_ready, res_valid, result, ovf
  );
`else
  modport master (
    output start, len, in_valid, a_vec, b_vec, res_ready,
    input  busy, in_ready, res_valid, result
  );
  modport slave (
    input  start, len, in_valid, a_vec, b_vec, res_ready,
    output busy, in_ready, res_valid, result
  );
`endif
endinterface

// File: rtl/dot_product_ctrl.sv
// Sequences an arbitrary-length dot product over an external N-lane reduction tree.
// Optional sticky overflow flag enabled by defining DOT_CTRL_OVF_EN.
module dot_product_ctrl #(
  parameter int unsigned N     = 8,
  parameter int unsigned LEN_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  dot_product_ctrl_if.slave bus,
  output logic [32*N-1:0]   tree_in,
  input  logic [31:0]       tree_sum
);
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  cnt_nxt_c;
  logic [DW-1:0]     acc;
  logic              prod_vld;
  logic              busy_q;
  logic              in_ready_q;
  logic              res_valid_q;
  logic [DW-1:0]     result_q;
  logic [DW*N-1:0]   prod_c;

  // Lane-wise products, truncated to the low 32 bits
  always_comb begin
    prod_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      prod_c[DW*i +: DW] = bus.a_vec[DW*i +: DW] * bus.b_vec[DW*i +: DW];
    end
  end

  assign cnt_nxt_c = cnt + LEN_W'(1);

`ifdef DOT_CTRL_OVF_EN
  logic          ovf_q;
  logic [DW:0]   sum_c;
  assign sum_c   = {1'b0, acc} + {1'b0, tree_sum};
  assign bus.ovf = ovf_q;
`endif

  // Control FSM, stage-1 product register and stage-2 accumulator
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      len_q       <= '0;
      cnt         <= '0;
      acc         <= '0;
      prod_vld    <= 1'b0;
      tree_in     <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      result_q    <= '0;
`ifdef DOT_CTRL_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      prod_vld <= 1'b0;
      if (prod_vld) begin
`ifdef DOT_CTRL_OVF_EN
        acc <= sum_c[DW-1:0];
        if (sum_c[DW]) ovf_q <= 1'b1;
`else
        acc <= acc + tree_sum;
`endif
      end

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            acc    <= '0;
            cnt    <= '0;
            len_q  <= bus.len;
            busy_q <= 1'b1;
`ifdef DOT_CTRL_OVF_EN
            ovf_q  <= 1'b0;
`endif
            if (bus.len == '0) begin
              state       <= S_DONE;
              res_valid_q <= 1'b1;
              result_q    <= '0;
            end else begin
              state      <= S_RUN;
              in_ready_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (bus.in_valid && in_ready_q) begin
            tree_in  <= prod_c;
            prod_vld <= 1'b1;
            cnt      <= cnt_nxt_c;
            if (cnt_nxt_c == len_q) begin
              in_ready_q <= 1'b0;
              state      <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Last product is folded into acc on the edge where prod_vld is still set
          if (!prod_vld) begin
            state       <= S_DONE;
            res_valid_q <= 1'b1;
            result_q    <= acc;
          end
        end
        S_DONE: begin
          if (bus.res_ready) begin
            state       <= S_IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.result    = result_q;
endmodule

// File: tb/tb_dot_product_ctrl.sv
// Directed self-checking bench for dot_product_ctrl; models the reduction tree as a lane sum.
module tb_dot_product_ctrl;
  localparam int unsigned N     = 8;
  localparam int unsigned LEN_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [32*N-1:0]   tree_in;
  logic [31:0]       tree_sum;
  int                checks   = 0;
  int                failures = 0;

  dot_product_ctrl_if #(.N(N), .LEN_W(LEN_W)) bus ();

  dot_product_ctrl #(.N(N), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .tree_in  (tree_in),
    .tree_sum (tree_sum)
  );

  always #5 clk = ~clk;

  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < int'(N); i++) tree_sum = tree_sum + tree_in[32*i +: 32];
  end

  // Lane i = base + step*i
  function automatic logic [32*N-1:0] vec_ramp(input logic [31:0] base, input logic [31:0] step);
    logic [32*N-1:0] v;
    for (int i = 0; i < int'(N); i++) v[32*i +: 32] = base + step * 32'(i);
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
    bus.a_vec = '0; bus.b_vec = '0; bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.res_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: busy=%b in_ready=%b res_valid=%b, want 0 0 0", bus.busy, bus.in_ready, bus.res_valid);
    end
    checks++;
    if (bus.result !== 32'd0 || tree_in !== '0) begin
      failures++;
      $display("FAIL reset_data: result=%h tree_in=%h, want 0", bus.result, tree_in);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_beat();
    @(negedge clk); bus.start = 1'b1; bus.len = 16'd1;
    @(negedge clk); bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_accept: busy=%b in_ready=%b, want 1 1", bus.busy, bus.in_ready);
    end
    bus.in_valid = 1'b1; bus.a_vec = vec_ramp(32'd1, 32'd1); bus.b_vec = vec_ramp(32'd1, 32'd0);
    @(negedge clk); bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b0 || tree_in !== vec_ramp(32'd1, 32'd1)) begin
      failures++;
      $display("FAIL single_stage1: in_ready=%b res_valid=%b tree_in=%h, want 0 0 ramp", bus.in_ready, bus.res_valid, tree_in);
    end
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early: res_valid=%b one edge after beat, want 0", bus.res_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b1 || bus.result !== 32'd36) begin
      failures++;
      $display("FAIL single_result: res_valid=%b result=%0d, want 1 36", bus.res_valid, bus.result);
    end
    bus.res_ready = 1'b1;
    @(negedge clk); bus.res_ready = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL single_handshake: res_valid=%b busy=%b, want 0 0", bus.res_valid, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int rdy_cnt = 0;
    int rv_first = -1;
    logic [31:0] rv_result = '0;
    logic busy5 = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.len = 16'd4; bus.res_ready = 1'b1;
    bus.a_vec = vec_ramp(32'd2, 32'd0); bus.b_vec = vec_ramp(32'd2, 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) begin bus.start = 1'b0; bus.in_valid = 1'b1; end
      if (bus.in_ready === 1'b1) rdy_cnt++;
      if (bus.res_valid === 1'b1 && rv_first < 0) begin rv_first = k; rv_result = bus.result; end
      if (k == 5) busy5 = bus.busy;
    end
    bus.in_valid = 1'b0; bus.res_ready = 1'b0;
    checks++;
    if (rdy_cnt != 4) begin
      failures++;
      $display("FAIL b2b_in_ready_cycles: got %0d, want 4", rdy_cnt);
    end
    checks++;
    if (rv_first != 6 || rv_result !== 32'd128) begin
      failures++;
      $display("FAIL b2b_result: res_valid at cycle %0d result=%0d, want cycle 6 result 128", rv_first, rv_result);
    end
    checks++;
    if (busy5 !== 1'b1 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_early_ready: busy_drain=%b busy_end=%b res_valid=%b, want 1 0 0", busy5, bus.busy, bus.res_valid);
    end
  endtask

  task automatic test_gaps_backpressure();
    int sent = 0;
    logic [31:0] expv = '0;
    logic [31:0] beat_sum;
    bit got = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.len = 16'd3;
    @(negedge clk); bus.start = 1'b0;
    for (int k = 0; k < 20 && sent < 3; k++) begin
      bus.in_valid = k[0];
      bus.a_vec = vec_ramp(32'd1, 32'd1);
      bus.b_vec = vec_ramp(32'(sent + 1), 32'd0);
      if (bus.in_valid && bus.in_ready === 1'b1) begin
        beat_sum = '0;
        for (int i = 0; i < int'(N); i++) beat_sum = beat_sum + 32'(i + 1) * 32'(sent + 1);
        expv = expv + beat_sum;
        sent++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (sent != 3) begin
      failures++;
      $display("FAIL gaps_beats: sent %0d beats, want 3", sent);
    end
    for (int k = 0; k < 10 && !got; k++) begin
      if (bus.res_valid === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL gaps_timeout: res_valid=%b, want 1 within 10 cycles", bus.res_valid);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.res_valid !== 1'b1 || bus.result !== expv) begin
        failures++;
        $display("FAIL gaps_hold%0d: res_valid=%b result=%0d, want 1 %0d", k, bus.res_valid, bus.result, expv);
      end
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    @(negedge clk); bus.res_ready = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b0) begin
      failures++;
      $display("FAIL gaps_handshake: res_valid=%b, want 0", bus.res_valid);
    end
  endtask

  task automatic test_zero_len();
    @(negedge clk); bus.start = 1'b1; bus.len = 16'd0;
    @(negedge clk); bus.start = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b1 || bus.result !== 32'd0 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL zero_len: res_valid=%b result=%0d in_ready=%b, want 1 0 0", bus.res_valid, bus.result, bus.in_ready);
    end
    bus.res_ready = 1'b1;
    @(negedge clk); bus.res_ready = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_len_done: res_valid=%b in_ready=%b busy=%b, want 0 0 0", bus.res_valid, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_mid_reset();
    bit got = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.len = 16'd4;
    @(negedge clk); bus.start = 1'b0; bus.in_valid = 1'b1;
    bus.a_vec = vec_ramp(32'd3, 32'd0); bus.b_vec = vec_ramp(32'd3, 32'd0);
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.res_valid !== 1'b0 ||
        bus.result !== 32'd0 || tree_in !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: busy=%b in_ready=%b res_valid=%b result=%0d tree_in=%h, want all 0",
               bus.busy, bus.in_ready, bus.res_valid, bus.result, tree_in);
    end
    bus.start = 1'b1; bus.len = 16'd1;
    @(negedge clk); bus.start = 1'b0; bus.in_valid = 1'b1;
    bus.a_vec = vec_ramp(32'd1, 32'd1); bus.b_vec = vec_ramp(32'd1, 32'd0);
    @(negedge clk); bus.in_valid = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (bus.res_valid === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!got || bus.result !== 32'd36) begin
      failures++;
      $display("FAIL midreset_newjob: res_valid=%b result=%0d, want 1 36", bus.res_valid, bus.result);
    end
    bus.res_ready = 1'b1;
    @(negedge clk); bus.res_ready = 1'b0;
  endtask

`ifdef DOT_CTRL_OVF_EN
  task automatic test_ovf();
    bit got = 1'b0;
    logic [32*N-1:0] a_ovf = '0;
    a_ovf[31:0] = 32'h8000_0000;
    @(negedge clk); bus.start = 1'b1; bus.len = 16'd2;
    @(negedge clk); bus.start = 1'b0; bus.in_valid = 1'b1;
    bus.a_vec = a_ovf; bus.b_vec = vec_ramp(32'd1, 32'd0);
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (bus.res_valid === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!got || bus.result !== 32'd0 || bus.ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set: res_valid=%b result=%0d ovf=%b, want 1 0 1", bus.res_valid, bus.result, bus.ovf);
    end
    bus.res_ready = 1'b1;
    @(negedge clk); bus.res_ready = 1'b0;
    bus.start = 1'b1; bus.len = 16'd1;
    @(negedge clk); bus.start = 1'b0; bus.in_valid = 1'b1;
    bus.a_vec = vec_ramp(32'd1, 32'd1); bus.b_vec = vec_ramp(32'd1, 32'd0);
    @(negedge clk); bus.in_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (bus.res_valid === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!got || bus.result !== 32'd36 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: res_valid=%b result=%0d ovf=%b, want 1 36 0", bus.res_valid, bus.result, bus.ovf);
    end
    bus.res_ready = 1'b1;
    @(negedge clk); bus.res_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_gaps_backpressure();
    test_zero_len();
    test_mid_reset();
`ifdef DOT_CTRL_OVF_EN
    test_ovf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
